// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serialising arbiter for the shared unified RAM port (IF fetch vs. MEM load/store).
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: round-robin grant when IF and MEM collide in IDLE.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_data,
   output logic              if_done,
   output logic              if_stall,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_len,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_done,
   output logic              mem_stall,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_dout,
   output logic              ram_wr,
   input  logic [7:0]        ram_din
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_IF_RD  = 2'd1,
      S_MEM_RD = 2'd2,
      S_MEM_WR = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        nbytes_q, nbytes_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rbuf_q, rbuf_d;
   logic [31:0]       if_data_q, if_data_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   logic              grant_mem, grant_if;
   logic [1:0]        rd_idx;
   logic [31:0]       rd_word;
   logic [2:0]        grant_n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic              ptr_q, ptr_d;   // 1: IF holds priority on the next collision
`endif

   function automatic logic [2:0] len_to_n(input logic [1:0] len);
      case (len)
         2'b00:   len_to_n = 3'd1;
         2'b01:   len_to_n = 3'd2;
         default: len_to_n = 3'd4;
      endcase
   endfunction

   function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
      case (idx)
         2'd0:    get_byte = w[7:0];
         2'd1:    get_byte = w[15:8];
         2'd2:    get_byte = w[23:16];
         default: get_byte = w[31:24];
      endcase
   endfunction

   function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                            input logic [7:0] b);
      put_byte = w;
      case (idx)
         2'd0:    put_byte[7:0]   = b;
         2'd1:    put_byte[15:8]  = b;
         2'd2:    put_byte[23:16] = b;
         default: put_byte[31:24] = b;
      endcase
   endfunction

   // ram_din carries the byte addressed in the previous cycle, hence cnt-1.
   assign rd_idx  = 2'(cnt_q - 3'd1);
   assign rd_word = put_byte(rbuf_q, rd_idx, ram_din);
   assign grant_n = len_to_n(mem_len);

   always_comb begin
      grant_mem = 1'b0;
      grant_if  = 1'b0;
      if (state_q == S_IDLE && !rst) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         grant_mem = mem_req && (!if_req || !ptr_q);
         grant_if  = if_req && !grant_mem;
`else
         grant_mem = mem_req;
         grant_if  = if_req && !mem_req;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      nbytes_d    = nbytes_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      rbuf_d      = rbuf_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      ram_addr    = '0;
      ram_dout    = 8'd0;
      ram_wr      = 1'b0;
      if_done     = 1'b0;
      mem_done    = 1'b0;
      if_data     = if_data_q;
      mem_rdata   = mem_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_d       = ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            // Byte 0 goes out in the grant cycle straight from the live request.
            if (grant_mem) begin
               base_d   = mem_addr;
               wdata_d  = mem_wdata;
               nbytes_d = grant_n;
               rbuf_d   = 32'd0;
               ram_addr = mem_addr;
               cnt_d    = 3'd1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
               ptr_d    = 1'b1;
`endif
               if (mem_we) begin
                  ram_wr   = 1'b1;
                  ram_dout = mem_wdata[7:0];
                  if (grant_n == 3'd1) begin
                     mem_done = 1'b1;
                     cnt_d    = 3'd0;
                  end else begin
                     state_d = S_MEM_WR;
                  end
               end else begin
                  state_d = S_MEM_RD;
               end
            end else if (grant_if) begin
               base_d   = if_addr;
               nbytes_d = 3'd4;
               rbuf_d   = 32'd0;
               ram_addr = if_addr;
               cnt_d    = 3'd1;
               state_d  = S_IF_RD;
`ifdef MEM_ARB_ROUND_ROBIN_EN
               ptr_d    = 1'b0;
`endif
            end
         end
         S_IF_RD, S_MEM_RD: begin
            rbuf_d = rd_word;
            if (cnt_q == nbytes_q) begin
               state_d = S_IDLE;
               cnt_d   = 3'd0;
               if (state_q == S_IF_RD) begin
                  if_done   = 1'b1;
                  if_data   = rd_word;
                  if_data_d = rd_word;
               end else begin
                  mem_done    = 1'b1;
                  mem_rdata   = rd_word;
                  mem_rdata_d = rd_word;
               end
            end else begin
               ram_addr = base_q + ADDR_W'(cnt_q);
               cnt_d    = cnt_q + 3'd1;
            end
         end
         S_MEM_WR: begin
            ram_addr = base_q + ADDR_W'(cnt_q);
            ram_dout = get_byte(wdata_q, cnt_q[1:0]);
            ram_wr   = 1'b1;
            if (cnt_q == nbytes_q - 3'd1) begin
               mem_done = 1'b1;
               state_d  = S_IDLE;
               cnt_d    = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign if_stall  = if_req && !if_done;
   assign mem_stall = mem_req && !mem_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         if_data_q   <= 32'd0;
         mem_rdata_q <= 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         ptr_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   // Latched request fields are only meaningful while a transaction is in flight.
   always_ff @(posedge clk) begin
      nbytes_q <= nbytes_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      rbuf_q   <= rbuf_d;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench for mem_arbiter with a transaction-level schedule and memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_data;
   logic        if_done, if_stall;
   logic        mem_req, mem_we;
   logic [1:0]  mem_len;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_done, mem_stall;
   logic [31:0] ram_addr;
   logic [7:0]  ram_dout;
   logic        ram_wr;
   logic [7:0]  ram_din = 8'd0;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0]  ram_m  [logic [31:0]];
   logic [7:0]  shadow [logic [31:0]];
   logic [31:0] last_if  = 32'd0;
   logic [31:0] last_mrd = 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   bit          m_ptr_if = 1'b0;
`endif

   logic        s_wr = 1'b0;
   logic [31:0] s_addr = 32'd0;
   logic [7:0]  s_dout = 8'd0;

   mem_arbiter #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done), .if_stall(if_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
      .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] ram_get(input logic [31:0] a);
      return ram_m.exists(a) ? ram_m[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] sh_get(input logic [31:0] a);
      return shadow.exists(a) ? shadow[a] : init_byte(a);
   endfunction

   function automatic logic [31:0] sh_word(input logic [31:0] a, input int n);
      logic [31:0] w;
      w = 32'd0;
      for (int k = 0; k < n; k++) w[8*k +: 8] = sh_get(a + 32'(k));
      return w;
   endfunction

   // RAM: one-cycle read latency, write on the edge ending the cycle.
   always @(negedge clk) begin
      s_wr   = ram_wr;
      s_addr = ram_addr;
      s_dout = ram_dout;
   end

   always @(posedge clk) begin
      if (s_wr) ram_m[s_addr] = s_dout;
      ram_din <= ram_get(s_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [31:0] a, input logic [7:0] b);
      ram_m[a]  = b;
      shadow[a] = b;
   endtask

   task automatic mem_effect(input bit we, input int nm, input logic [31:0] ma,
                             input logic [31:0] wd, output logic [31:0] rd);
      rd = 32'd0;
      if (we) begin
         for (int k = 0; k < nm; k++) shadow[ma + 32'(k)] = wd[8*k +: 8];
      end else begin
         rd = sh_word(ma, nm);
      end
   endtask

   task automatic run_txn(input bit do_if, input logic [31:0] ia, input bit do_mem, input bit we,
                          input logic [1:0] len, input logic [31:0] ma, input logic [31:0] wd);
      int          nm, g_if, d_if, g_mem, d_mem, last;
      bit          mem_first, e_ifd, e_md, e_wr, e_ac;
      logic [31:0] exp_if_w, exp_m_w, e_addr;
      logic [7:0]  e_dout;
      nm = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      mem_first = do_mem && (!do_if || !m_ptr_if);
`else
      mem_first = do_mem;
`endif
      g_if = -1000; d_if = -1000; g_mem = -1000; d_mem = -1000;
      exp_if_w = 32'd0; exp_m_w = 32'd0;
      if (mem_first) begin
         g_mem = 0;
         d_mem = we ? nm - 1 : nm;
         mem_effect(we, nm, ma, wd, exp_m_w);
         if (do_if) begin
            g_if = d_mem + 1;
            d_if = g_if + 4;
            exp_if_w = sh_word(ia, 4);
         end
      end else begin
         g_if = 0;
         d_if = 4;
         exp_if_w = sh_word(ia, 4);
         if (do_mem) begin
            g_mem = 5;
            d_mem = g_mem + (we ? nm - 1 : nm);
            mem_effect(we, nm, ma, wd, exp_m_w);
         end
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (mem_first) m_ptr_if = !do_if;
      else m_ptr_if = do_mem;
`endif
      last = (d_if > d_mem) ? d_if : d_mem;

      @(posedge clk); #1;
      if_req = do_if; if_addr = ia;
      mem_req = do_mem; mem_we = we; mem_len = len; mem_addr = ma; mem_wdata = wd;
      for (int c = 0; c <= last; c++) begin
         @(negedge clk);
         e_ifd = (c == d_if);
         e_md  = (c == d_mem);
         e_wr = 1'b0; e_ac = 1'b0; e_addr = 32'd0; e_dout = 8'd0;
         if (do_mem && c >= g_mem && c < g_mem + nm) begin
            e_ac   = 1'b1;
            e_addr = ma + 32'(c - g_mem);
            if (we) begin
               e_wr   = 1'b1;
               e_dout = wd[8*(c - g_mem) +: 8];
            end
         end
         if (do_if && c >= g_if && c < g_if + 4) begin
            e_ac   = 1'b1;
            e_addr = ia + 32'(c - g_if);
         end
         if (e_ifd) last_if = exp_if_w;
         if (e_md && !we) last_mrd = exp_m_w;
         chk("ram_wr", 32'(ram_wr), 32'(e_wr));
         if (e_ac) chk("ram_addr", ram_addr, e_addr);
         if (e_wr) chk("ram_dout", 32'(ram_dout), 32'(e_dout));
         chk("if_done", 32'(if_done), 32'(e_ifd));
         chk("mem_done", 32'(mem_done), 32'(e_md));
         chk("if_data", if_data, last_if);
         chk("mem_rdata", mem_rdata, last_mrd);
         chk("if_stall", 32'(if_stall), 32'(do_if && c < d_if));
         chk("mem_stall", 32'(mem_stall), 32'(do_mem && c < d_mem));
         @(posedge clk); #1;
         if (e_ifd) if_req = 1'b0;
         if (e_md) mem_req = 1'b0;
         if (do_if && c >= g_if) if_addr = $urandom;
         if (do_mem && c >= g_mem) begin
            mem_addr = $urandom; mem_wdata = $urandom;
            mem_len = 2'($urandom); mem_we = 1'($urandom);
         end
      end
      if (do_mem && we)
         for (int k = 0; k < nm; k++) chk("ram_byte", 32'(ram_get(ma + 32'(k))), 32'(sh_get(ma + 32'(k))));
   endtask

   task automatic reset_mid_store;
      @(posedge clk); #1;
      mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h80; mem_wdata = 32'h11223344;
      @(negedge clk);
      chk("rst_c0_wr", 32'(ram_wr), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_c2_wr", 32'(ram_wr), 32'd1);
      chk("rst_c2_addr", ram_addr, 32'h82);
      chk("rst_c2_done", 32'(mem_done), 32'd0);
      @(posedge clk); #1;
      last_if = 32'd0; last_mrd = 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      m_ptr_if = 1'b0;
`endif
      @(negedge clk);
      chk("rst_c3_wr", 32'(ram_wr), 32'd0);
      chk("rst_c3_done", 32'(mem_done), 32'd0);
      chk("rst_c3_ifdata", if_data, 32'd0);
      chk("rst_c3_mrdata", mem_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; mem_req = 1'b0;
      @(negedge clk);
      chk("rst_c4_wr", 32'(ram_wr), 32'd0);
      chk("rst_c4_done", 32'(mem_done), 32'd0);
      shadow[32'h80] = 8'h44; shadow[32'h81] = 8'h33; shadow[32'h82] = 8'h22;
      chk("rst_partial", 32'(ram_get(32'h83)), 32'(init_byte(32'h83)));
      chk("rst_written", 32'(ram_get(32'h82)), 32'h22);
      // Fetch straight after the abort must be granted at once from IDLE.
      run_txn(1'b1, 32'h80, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
      chk("rst_readback", if_data, {init_byte(32'h83), 8'h22, 8'h33, 8'h44});
   endtask

   initial begin
      rst = 1'b1;
      if_req = 1'b0; if_addr = 32'd0;
      mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'd0; mem_wdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ram_wr", 32'(ram_wr), 32'd0);
      chk("rst_ram_addr", ram_addr, 32'd0);
      chk("rst_if_done", 32'(if_done), 32'd0);
      chk("rst_mem_done", 32'(mem_done), 32'd0);
      chk("rst_if_data", if_data, 32'd0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
      run_txn(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
      chk("plan_if_data", if_data, 32'h00000513);

      poke(32'h2003, 8'hF0);
      run_txn(1'b0, 32'd0, 1'b1, 1'b0, 2'b00, 32'h2003, 32'd0);
      chk("plan_lb", mem_rdata, 32'h000000F0);

      run_txn(1'b0, 32'd0, 1'b1, 1'b1, 2'b10, 32'h40, 32'hDEADBEEF);
      chk("plan_sw0", 32'(ram_get(32'h40)), 32'hEF);
      chk("plan_sw3", 32'(ram_get(32'h43)), 32'hDE);

      run_txn(1'b1, 32'h100, 1'b1, 1'b0, 2'b01, 32'h2002, 32'd0);

      reset_mid_store();

      run_txn(1'b0, 32'd0, 1'b1, 1'b0, 2'b10, 32'hFFFFFFFE, 32'd0);
      run_txn(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 2'b11, 32'hFFFFFFFD, 32'hCAFEF00D);

      for (int i = 0; i < 40; i++) begin
         int          sel;
         logic [31:0] ia, ma;
         sel = $urandom_range(0, 2);
         ia = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFD : 32'($urandom_range(0, 63));
         ma = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFE : 32'($urandom_range(0, 63));
         run_txn(sel != 1, ia, sel != 0, 1'($urandom), 2'($urandom), ma, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequencer and arbiter for the single byte-wide unified RAM port shared by instruction fetch (IF) and load/store (MEM).
- Serialises 32-bit fetches and 1/2/4-byte loads/stores into byte accesses.
- Returns assembled words and raises if_stall / mem_stall into the pipeline stall unit until each request completes.

Parameters:
ADDR_W, 32, width of byte addresses on all ports.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high (rst == 1 resets on the clk rising edge)
if_req  input  1  IF requests a 32-bit instruction read
if_addr  input  ADDR_W  IF byte address
if_data  output  32  fetched instruction, little-endian
if_done  output  1  one-cycle pulse: if_data valid
if_stall  output  1  IF request pending and not completing this cycle
mem_req  input  1  MEM requests an access
mem_we  input  1  1 = store, 0 = load
mem_len  input  2  00 byte, 01 half, 10 word, 11 treated as word
mem_addr  input  ADDR_W  MEM byte address
mem_wdata  input  32  store data; low bytes used
mem_rdata  output  32  load data, zero-extended
mem_done  output  1  one-cycle pulse: access complete
mem_stall  output  1  MEM request pending and not completing this cycle
ram_addr  output  ADDR_W  RAM byte address
ram_dout  output  8  RAM write byte
ram_wr  output  1  1 = write ram_dout at ram_addr this cycle
ram_din  input  8  RAM read byte; valid the cycle after its address is driven

Behaviour:
- Reset values: all outputs 0, state IDLE, byte counter 0, priority pointer = MEM.
- States: IDLE, IF_RD, MEM_RD, MEM_WR.
- IDLE, grant rules:
  - mem_req only: MEM_RD or MEM_WR per mem_we.
  - if_req only: IF_RD.
  - Both: MEM wins.
  - Request, address, len, we and wdata are latched at grant. Later input changes are ignored until done.
- Byte count: n = 4 for IF; 1/2/4 for MEM per mem_len.
- Read states (IF_RD, MEM_RD):
  - Cycle k (k = 0..n-1): drive ram_addr = base+k, ram_wr = 0.
  - Byte returned on ram_din in cycle k+1 is written to result bits [8k+7:8k].
  - Done pulse and result output in cycle n, i.e. read latency n+1 cycles from grant.
  - Unfetched upper bytes are 0.
- MEM_WR:
  - Cycle k: ram_addr = base+k, ram_dout = wdata[8k+7:8k], ram_wr = 1.
  - mem_done pulses in cycle n-1, together with the last write, so write latency is n cycles.
- Leaving IDLE:
  - The grant cycle is cycle 0; address k=0 is driven in the same cycle as the grant (combinational from the latched/selected request).
  - After done, return to IDLE. A new grant is possible in the next cycle; there is no back-to-back issue in the done cycle.
- Data hold: if_data and mem_rdata hold their last value until the next completion of the same requester.
- Stall outputs:
  - if_stall = if_req && !if_done. mem_stall = mem_req && !mem_done. Both are combinational.
  - A requester that is waiting for a grant also stalls.
- No preemption: a transaction in flight always completes.
- Request dropped mid-transaction: the transaction still completes and the done pulse is still emitted.
- Address wrap: base+k wraps modulo 2^ADDR_W.
- Misalignment: no alignment check; misaligned accesses are performed bytewise.
- Reset mid-transaction:
  - Aborts immediately: state IDLE, ram_wr = 0 from that edge, no done pulse.
  - Partially written bytes stay written.
- ram_wr is 0 in every non-MEM_WR state.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN
- Defined:
  - When both requests are present in IDLE, grant goes to the requester indicated by the priority pointer.
  - After each grant, the pointer flips to the other requester.
  - A lone request is granted regardless of the pointer.
- Undefined: fixed MEM-over-IF priority; pointer logic absent.

Test Plan:
- IF only: if_req=1, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00.
  - Expected: ram_addr 0x100..0x103 in cycles 0-3; if_done in cycle 4; if_data=0x00000513; if_stall=1 in cycles 0-3.
- MEM byte load: mem_len=00, mem_addr=0x2003, RAM[0x2003]=0xF0.
  - Expected: mem_done in cycle 1; mem_rdata=0x000000F0.
- MEM word store: mem_we=1, mem_len=10, mem_addr=0x40, mem_wdata=0xDEADBEEF.
  - Expected: ram_wr=1 in cycles 0-3 writing EF,BE,AD,DE to 0x40..0x43; mem_done in cycle 3.
- Simultaneous requests: if_req and mem_req (half load) both asserted.
  - Expected: MEM served first with mem_done in cycle 2; IF granted in cycle 3; if_done in cycle 7; if_stall held until then.
  - With MEM_ARB_ROUND_ROBIN_EN and pointer=IF: IF served first instead.
- Reset and wrap:
  - rst asserted in cycle 2 of a word store: ram_wr=0 from the next edge, no mem_done, state IDLE.
  - Word load at address 0xFFFFFFFE: addresses FFFFFFFE, FFFFFFFF, 0, 1 are driven.
